stream_serializer: RTL and testbench
====================================

Name: stream_serializer

Overview:
- Consumes wide words on a valid/ready stream and emits each word as N_BEATS narrow beats on a downstream valid/ready stream, with a last-beat marker.
- Sits at the narrow end of datapath width transitions, e.g. feeding a narrow link or a narrow FIFO from a wide producer.
- Holds one wide word. Consecutive words stream with no idle cycle between them.

Parameters:
- T_w, 8: width of one output beat in bits; must be >= 1.
- N_BEATS, 4: output beats per input word; must be >= 2.
- LSB_FIRST, 1'b1: 1 sends beat 0 = data_i[T_w-1:0] first; 0 sends the most significant slice first.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous reset, active low.
- clr_i  in  1  synchronous clear.
- valid_i  in  1  input word valid.
- ready_o  out  1  input word accepted when valid_i & ready_o.
- data_i  in  T_w*N_BEATS  input word.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream ready; a beat transfers when valid_o & ready_i.
- data_o  out  T_w  current output beat.
- last_o  out  1  high with the final beat of a word.

Behaviour:
- State: wide holding register `word_q`, beat counter `cnt_q` of width max(1,$clog2(N_BEATS)), FSM {IDLE, SEND}.
- Reset (rst_ni low, asynchronous):
  - FSM = IDLE, cnt_q = 0, word_q = 0.
  - Outputs: valid_o = 0, last_o = 0, data_o = 0, ready_o = 1.
- IDLE:
  - ready_o = ~clr_i, valid_o = 0.
  - On valid_i & ready_o: word_q <= data_i, cnt_q <= 0, next state SEND.
- SEND:
  - valid_o = 1.
  - data_o = slice of word_q. With LSB_FIRST, slice index = cnt_q; otherwise N_BEATS-1-cnt_q.
  - last_o = (cnt_q == N_BEATS-1).
- Beat transfer in SEND (valid_o & ready_i):
  - If not last: cnt_q <= cnt_q+1.
  - If last: cnt_q <= 0. If valid_i in the same cycle, capture data_i into word_q and stay in SEND; otherwise go to IDLE.
- ready_o in SEND:
  - ready_o = last_o & ready_i & ~clr_i.
  - This is a combinational path ready_i -> ready_o. It is intended: it gives back-to-back words with no bubble.
- Latency: a word accepted in cycle t presents its first beat with valid_o = 1 in cycle t+1. There is no fall-through.
- Throughput: one beat per cycle while ready_i is held high. N_BEATS cycles per word, sustained.
- Output stability: while valid_o & ~ready_i, data_o and last_o stay stable and valid_o stays high. valid_o never drops without a transfer, except on clr_i or reset.
- Input side: the block makes no assumption on valid_i stability before acceptance.
- data_o is driven from word_q in every state. In IDLE it shows a stale slice, which is don't-care while valid_o = 0.
- clr_i (synchronous, highest priority over all handshakes):
  - Next state IDLE, cnt_q <= 0. word_q is retained (don't-care).
  - The in-flight word is dropped; remaining beats are never emitted.
  - While clr_i is high, ready_o = 0, so no word is accepted.
  - A beat presented in the clr_i cycle with ready_i high counts as transferred by downstream. The block simply does not continue the word.
- Reset mid-word: all progress is lost; the outputs take the reset values immediately (asynchronous).
- Counter wrap: cnt_q never exceeds N_BEATS-1. The non-power-of-two N_BEATS case must wrap at N_BEATS-1, not at 2^width-1.

Test Plan:
- Single word, T_w=8, N_BEATS=4, LSB_FIRST=1, data_i=32'hDDCCBBAA, ready_i held 1:
  - Accepted in cycle 0.
  - Beats AA, BB, CC, DD in cycles 1-4, last_o only with DD.
  - valid_o = 0 in cycle 5.
  - ready_o = 0 in cycles 1-3 and ready_o = 1 in cycle 4.
- Back-to-back, valid_i held with 32'h03020100 then 32'h07060504:
  - Eight consecutive beats 00..07 with no gap.
  - Second word accepted in the same cycle as beat 03.
- Backpressure: ready_i low for 3 cycles during beat BB -> data_o = BB, valid_o = 1 and last_o = 0 held stable; sequence resumes unchanged.
- LSB_FIRST=0, data_i=32'hDDCCBBAA -> beats DD, CC, BB, AA; last_o with AA.
- N_BEATS=3, T_w=4, data_i=12'h321, run 3 words -> beats 1,2,3 repeating; cnt_q wraps 2->0 correctly.
- Clear and reset:
  - clr_i pulsed during beat BB -> next cycle valid_o = 0 and ready_o = 1; a new word 32'h44332211 yields 11, 22, 33, 44.
  - rst_ni asserted mid-word -> valid_o = 0 and last_o = 0 immediately.

Source files
------------

// File: rtl/stream_serializer.sv
// Wide-to-narrow stream serializer: holds one wide word and emits it as N_BEATS narrow beats
// with a last-beat marker. Back-to-back words stream with no idle cycle between them.
module stream_serializer #(
    parameter int unsigned T_w       = 8,
    parameter int unsigned N_BEATS   = 4,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [T_w*N_BEATS-1:0] data_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [T_w-1:0]         data_o,
    output logic                   last_o
);
    localparam int unsigned    CntW    = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(N_BEATS - 1);

    typedef enum logic {StIdle, StSend} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [CntW-1:0]        sel;
    logic [T_w*N_BEATS-1:0] word_q, word_d;
    logic                   accept;

    // ready_i -> ready_o is combinational on the last beat so the next word loads without a bubble.
    always_comb begin
        valid_o = (state_q == StSend);
        last_o  = valid_o && (cnt_q == LastCnt);
        ready_o = !clr_i && ((state_q == StIdle) || (last_o && ready_i));
        accept  = valid_i && ready_o;
    end

    always_comb begin
        sel    = LSB_FIRST ? cnt_q : (LastCnt - cnt_q);
        data_o = '0;
        for (int unsigned i = 0; i < N_BEATS; i++) begin
            if (sel == CntW'(i)) begin
                data_o = word_q[i*T_w +: T_w];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        if (clr_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (state_q == StIdle) begin
            if (accept) begin
                word_d  = data_i;
                cnt_d   = '0;
                state_d = StSend;
            end
        end else if (ready_i) begin
            if (last_o) begin
                cnt_d = '0;
                if (accept) begin
                    word_d = data_i;
                end else begin
                    state_d = StIdle;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: tb/tb_stream_serializer.sv
// Self-checking bench for stream_serializer: three instances (LSB-first, MSB-first, 3-beat)
// checked cycle by cycle against a beat-queue reference model.
module tb_stream_serializer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        clr, vin, rin;
    logic [31:0] din;
    logic        rdy0, v0, l0, rdy1, v1, l1;
    logic [7:0]  d0, d1;
    logic        clr3, vin3, rin3;
    logic [11:0] din3;
    logic        rdy3, v3, l3;
    logic [3:0]  d3;

    int n_cmp = 0;
    int n_err = 0;

    // Model: each queue holds the {last, data} beats still owed downstream for the held word.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [4:0] q3[$];

    stream_serializer #(.T_w(8), .N_BEATS(4), .LSB_FIRST(1'b1)) u_lsb (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .valid_i(vin), .ready_o(rdy0), .data_i(din),
        .valid_o(v0), .ready_i(rin), .data_o(d0), .last_o(l0)
    );

    stream_serializer #(.T_w(8), .N_BEATS(4), .LSB_FIRST(1'b0)) u_msb (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .valid_i(vin), .ready_o(rdy1), .data_i(din),
        .valid_o(v1), .ready_i(rin), .data_o(d1), .last_o(l1)
    );

    stream_serializer #(.T_w(4), .N_BEATS(3), .LSB_FIRST(1'b1)) u_n3 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr3), .valid_i(vin3), .ready_o(rdy3), .data_i(din3),
        .valid_o(v3), .ready_i(rin3), .data_o(d3), .last_o(l3)
    );

    function automatic logic [21:0] obs_pair();
        return {v0, l0, rdy0, (v0 ? d0 : 8'h00), v1, l1, rdy1, (v1 ? d1 : 8'h00)};
    endfunction

    function automatic logic [21:0] exp_pair();
        logic [8:0] h0, h1;
        logic       r0, r1;
        h0 = (q0.size() != 0) ? q0[0] : 9'h0;
        h1 = (q1.size() != 0) ? q1[0] : 9'h0;
        r0 = !clr && (q0.size() == 0 || (q0.size() == 1 && rin));
        r1 = !clr && (q1.size() == 0 || (q1.size() == 1 && rin));
        return {q0.size() != 0, h0[8], r0, h0[7:0], q1.size() != 0, h1[8], r1, h1[7:0]};
    endfunction

    function automatic logic [6:0] obs_n3();
        return {v3, l3, rdy3, (v3 ? d3 : 4'h0)};
    endfunction

    function automatic logic [6:0] exp_n3();
        logic [4:0] h;
        logic       r;
        h = (q3.size() != 0) ? q3[0] : 5'h0;
        r = !clr3 && (q3.size() == 0 || (q3.size() == 1 && rin3));
        return {q3.size() != 0, h[4], r, h[3:0]};
    endfunction

    // Advance the model by one clock: transfer, then clear, then accept.
    task automatic model_step();
        bit acc;
        acc = vin && !clr && (q0.size() == 0 || (q0.size() == 1 && rin));
        if (q0.size() != 0 && rin) void'(q0.pop_front());
        if (q1.size() != 0 && rin) void'(q1.pop_front());
        if (clr) begin
            q0.delete();
            q1.delete();
        end
        if (acc) begin
            for (int i = 0; i < 4; i++) begin
                q0.push_back({i == 3, din[8*i +: 8]});
                q1.push_back({i == 3, din[8*(3-i) +: 8]});
            end
        end
    endtask

    task automatic model_step_n3();
        bit acc;
        acc = vin3 && !clr3 && (q3.size() == 0 || (q3.size() == 1 && rin3));
        if (q3.size() != 0 && rin3) void'(q3.pop_front());
        if (clr3) q3.delete();
        if (acc) begin
            for (int i = 0; i < 3; i++) q3.push_back({i == 2, din3[4*i +: 4]});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; vin = 1'b0; rin = 1'b0; din = '0;
        clr3 = 1'b0; vin3 = 1'b0; rin3 = 1'b0; din3 = '0;
        #1;
        n_cmp++;
        if ({v0, l0, rdy0, d0, v1, l1, rdy1, d1} !== {3'b001, 8'h00, 3'b001, 8'h00}) begin
            n_err++;
            $display("FAIL reset_pair: got %h want %h", {v0, l0, rdy0, d0, v1, l1, rdy1, d1},
                     {3'b001, 8'h00, 3'b001, 8'h00});
        end
        n_cmp++;
        if ({v3, l3, rdy3, d3} !== 7'b001_0000) begin
            n_err++;
            $display("FAIL reset_n3: got %b want %b", {v3, l3, rdy3, d3}, 7'b001_0000);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        for (int c = 0; c < 7; c++) begin
            vin = (c == 0); din = (c == 0) ? 32'hDDCCBBAA : 32'h0; rin = 1'b1; clr = 1'b0;
            #1;
            n_cmp++;
            if (obs_pair() !== exp_pair()) begin
                n_err++;
                $display("FAIL single cyc%0d: got %h want %h", c, obs_pair(), exp_pair());
            end
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [2];
        int          idx;
        bit          acc;
        words[0] = 32'h03020100; words[1] = 32'h07060504; idx = 0;
        for (int c = 0; c < 11; c++) begin
            vin = (idx < 2); din = (idx < 2) ? words[idx] : 32'h0; rin = 1'b1; clr = 1'b0;
            #1;
            n_cmp++;
            if (obs_pair() !== exp_pair()) begin
                n_err++;
                $display("FAIL back_to_back cyc%0d: got %h want %h", c, obs_pair(), exp_pair());
            end
            acc = vin && (q0.size() == 0 || (q0.size() == 1 && rin));
            model_step();
            if (acc) idx++;
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 9; c++) begin
            vin = (c == 0); din = (c == 0) ? 32'hDDCCBBAA : 32'h0; clr = 1'b0;
            rin = !(c >= 2 && c <= 4);
            #1;
            n_cmp++;
            if (obs_pair() !== exp_pair()) begin
                n_err++;
                $display("FAIL backpressure cyc%0d: got %h want %h", c, obs_pair(), exp_pair());
            end
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic test_clear();
        for (int c = 0; c < 9; c++) begin
            vin = (c == 0) || (c == 3);
            din = (c == 0) ? 32'hDDCCBBAA : ((c == 3) ? 32'h44332211 : 32'h0);
            clr = (c == 2); rin = 1'b1;
            #1;
            n_cmp++;
            if (obs_pair() !== exp_pair()) begin
                n_err++;
                $display("FAIL clear cyc%0d: got %h want %h", c, obs_pair(), exp_pair());
            end
            model_step();
            @(negedge clk);
        end
        clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 2; c++) begin
            vin = (c == 0); din = 32'hDDCCBBAA; rin = 1'b1; clr = 1'b0;
            #1;
            n_cmp++;
            if (obs_pair() !== exp_pair()) begin
                n_err++;
                $display("FAIL reset_mid cyc%0d: got %h want %h", c, obs_pair(), exp_pair());
            end
            model_step();
            @(negedge clk);
        end
        vin = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({v0, l0, rdy0, d0, v1, l1, rdy1, d1} !== {3'b001, 8'h00, 3'b001, 8'h00}) begin
            n_err++;
            $display("FAIL reset_mid_async: got %h want %h", {v0, l0, rdy0, d0, v1, l1, rdy1, d1},
                     {3'b001, 8'h00, 3'b001, 8'h00});
        end
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 306; c++) begin
            if (c < 300) begin
                vin = 1'($urandom_range(0, 1)); din = $urandom;
                rin = ($urandom_range(0, 3) != 0); clr = ($urandom_range(0, 31) == 0);
            end else begin
                vin = 1'b0; rin = 1'b1; clr = 1'b0;
            end
            #1;
            n_cmp++;
            if (obs_pair() !== exp_pair()) begin
                n_err++;
                $display("FAIL random cyc%0d: got %h want %h", c, obs_pair(), exp_pair());
            end
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic test_n3();
        int idx;
        bit acc;
        idx = 0;
        for (int c = 0; c < 100; c++) begin
            if (c < 12) begin
                vin3 = (idx < 3); din3 = 12'h321; rin3 = 1'b1; clr3 = 1'b0;
            end else if (c < 94) begin
                vin3 = 1'($urandom_range(0, 1)); din3 = 12'($urandom);
                rin3 = ($urandom_range(0, 3) != 0); clr3 = ($urandom_range(0, 23) == 0);
            end else begin
                vin3 = 1'b0; rin3 = 1'b1; clr3 = 1'b0;
            end
            #1;
            n_cmp++;
            if (obs_n3() !== exp_n3()) begin
                n_err++;
                $display("FAIL n3 cyc%0d: got %b want %b", c, obs_n3(), exp_n3());
            end
            acc = vin3 && !clr3 && (q3.size() == 0 || (q3.size() == 1 && rin3));
            model_step_n3();
            if (acc) idx++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_random();
        test_n3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
